// File: rtl/gpr_pkg.sv
// Shared constants and state encoding for the GPR write-port arbiter.
// The arbiter's default widths come from here.
package gpr_pkg;

    localparam int GPR_ADDR_W   = 3;
    localparam int GPR_DATA_W   = 16;
    localparam int GPR_NUM_REGS = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_e;

    // Round-robin successor of idx among n requesters.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/gpr_write_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first set req bit found at or
// above rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        // NOTE: every variable written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = ID_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources and
// zero-clears all registers after reset or on clr_start.
module gpr_write_arbiter
    import gpr_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int ADDR_W   = GPR_ADDR_W,
    parameter  int DATA_W   = GPR_DATA_W,
    parameter  int NUM_REGS = GPR_NUM_REGS,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_start,
    output logic                      clr_busy,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      reg_write_en,
    output logic [ADDR_W-1:0]         reg_write_dest,
    output logic [DATA_W-1:0]         reg_write_data,
    output logic [ID_W-1:0]           grant_id
);

    state_e              state_q,    state_d;
    logic [ADDR_W-1:0]   clr_cnt_q,  clr_cnt_d;
    logic [ID_W-1:0]     rr_ptr_q,   rr_ptr_d;
    logic                wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0]   wr_dest_q,  wr_dest_d;
    logic [DATA_W-1:0]   wr_data_q,  wr_data_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]     arb_idx;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        wr_en_d    = 1'b0;
        wr_dest_d  = wr_dest_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        req_ready  = '0;

        case (state_q)
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_dest_d = clr_cnt_q;
                wr_data_d = '0;
                if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d   = ST_ARB;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_ARB: begin
                // A clear request wins over any pending writer this cycle.
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (|arb_grant) begin
                    req_ready  = arb_grant;
                    wr_en_d    = 1'b1;
                    wr_dest_d  = req_dest[int'(arb_idx)*ADDR_W +: ADDR_W];
                    wr_data_d  = req_data[int'(arb_idx)*DATA_W +: DATA_W];
                    grant_id_d = arb_idx;
                    rr_ptr_d   = ID_W'(next_idx(int'(arb_idx), NUM_REQ));
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            rr_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_dest_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_dest_q  <= wr_dest_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign clr_busy       = (state_q == ST_CLEAR);
    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;
    assign grant_id       = grant_id_q;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Scoreboard bench for gpr_write_arbiter: stimulus pushes expected port writes,
// a negedge monitor pops and compares them; a behavioural regfile tracks commits.
module tb_gpr_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 16;

    typedef struct {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
        logic [1:0]        gid;
        bit                chk_gid;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      clr_start;
    logic                      clr_busy;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_dest;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      reg_write_en;
    logic [ADDR_W-1:0]         reg_write_dest;
    logic [DATA_W-1:0]         reg_write_data;
    logic [1:0]                grant_id;

    logic [ADDR_W-1:0] dest_tab [NUM_REQ];
    logic [DATA_W-1:0] data_tab [NUM_REQ];
    logic [DATA_W-1:0] rf [8];
    bit                rf_init;
    exp_t              sb [$];
    int                checks = 0;
    int                errors = 0;

    gpr_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr_start      (clr_start),
        .clr_busy       (clr_busy),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dest       (req_dest),
        .req_data       (req_data),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .grant_id       (grant_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_dest = '0;
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_dest[i*ADDR_W +: ADDR_W] = dest_tab[i];
            req_data[i*DATA_W +: DATA_W] = data_tab[i];
        end
    end

    // Register file model: no reset, starts with a non-zero pattern.
    always @(posedge clk) begin
        if (!rf_init) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'hDEAD;
            rf_init <= 1'b1;
        end else if (reg_write_en) begin
            rf[reg_write_dest] <= reg_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write presented on the port must match the next expectation.
    always @(negedge clk) begin
        if (rst_n && reg_write_en) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(reg_write_dest), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_dest", 32'(reg_write_dest), 32'(e.dest));
                check("wr_data", 32'(reg_write_data), 32'(e.data));
                if (e.chk_gid) check("wr_gid", 32'(grant_id), 32'(e.gid));
            end
        end
    end

    task automatic push_clear(input int n);
        for (int a = 0; a < n; a++) sb.push_back('{ADDR_W'(a), 16'h0000, 2'd0, 1'b0});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wen"},   32'(reg_write_en),   32'd0);
        check({tag, "_dest"},  32'(reg_write_dest), 32'd0);
        check({tag, "_data"},  32'(reg_write_data), 32'd0);
        check({tag, "_gid"},   32'(grant_id),       32'd0);
        check({tag, "_busy"},  32'(clr_busy),       32'd1);
        check({tag, "_ready"}, 32'(req_ready),      32'd0);
    endtask

    // Called right after a negedge: drive valid, check the combinational grant,
    // record the expected write, advance one cycle.
    task automatic issue(input logic [3:0] v, input logic [3:0] exp_rdy, input int g, input string nm);
        req_valid = v;
        #1;
        check(nm, 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) sb.push_back('{dest_tab[g], data_tab[g], 2'(g), 1'b1});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        clr_start = 1'b0;
        req_valid = '0;
        dest_tab  = '{3'd0, 3'd1, 3'd5, 3'd1};
        data_tab  = '{16'hA000, 16'hA001, 16'hBEEF, 16'h1111};

        #3;
        check_reset_vals("por");
        @(negedge clk);
        @(negedge clk);

        // Clear after reset; valids held high to prove ready stays low.
        rst_n = 1'b1;
        push_clear(8);
        check("busy_release", 32'(clr_busy), 32'd1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            req_valid = 4'hF;
            #1;
            check("busy_clear", 32'(clr_busy), 32'd1);
            check("ready_clear", 32'(req_ready), 32'd0);
            req_valid = 4'h0;
        end
        @(negedge clk);
        check("busy_done", 32'(clr_busy), 32'd0);
        @(negedge clk);
        check("idle_after_clear", 32'(reg_write_en), 32'd0);
        for (int r = 0; r < 8; r++) check("rf_cleared", 32'(rf[r]), 32'h0000);

        // Single write from requester 2.
        issue(4'b0100, 4'b0100, 2, "rdy_single");
        req_valid = '0;
        @(negedge clk);
        check("rf5_beef", 32'(rf[5]), 32'hBEEF);

        // Requester 3 moves the pointer to 0, then full-load fairness.
        issue(4'b1000, 4'b1000, 3, "rdy_r3");
        dest_tab = '{3'd0, 3'd1, 3'd2, 3'd3};
        data_tab = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
        for (int i = 0; i < 6; i++) begin
            issue(4'hF, 4'(1 << (i % 4)), i % 4, "rdy_rr");
            check("no_bubble", 32'(reg_write_en), 32'd1);
        end

        // Pointer is 2: requesters 1 and 3 valid -> 3 then 1.
        issue(4'b1010, 4'b1000, 3, "rot_first");
        issue(4'b1010, 4'b0010, 1, "rot_second");
        req_valid = '0;

        // Same destination from requesters 2 and 0; last granted wins.
        dest_tab[0] = 3'd6; data_tab[0] = 16'h0AAA;
        dest_tab[2] = 3'd6; data_tab[2] = 16'h0222;
        issue(4'b0101, 4'b0100, 2, "same_a");
        issue(4'b0101, 4'b0001, 0, "same_b");
        req_valid = '0;
        dest_tab[0] = 3'd0; data_tab[0] = 16'h0123;
        @(negedge clk);
        check("rf6_last_wins", 32'(rf[6]), 32'h0AAA);

        // clr_start collides with requester 0; preceding write completes first.
        issue(4'b0010, 4'b0010, 1, "pre_clr");
        req_valid = 4'b0001;
        clr_start = 1'b1;
        #1;
        check("clr_collide_rdy", 32'(req_ready), 32'd0);
        push_clear(8);
        @(negedge clk);
        clr_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("busy_clr2", 32'(clr_busy), 32'd1);
            check("ready_clr2", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        issue(4'b0001, 4'b0001, 0, "post_clr_grant");
        req_valid = '0;
        @(negedge clk);
        check("rf6_cleared", 32'(rf[6]), 32'h0000);
        check("rf0_written", 32'(rf[0]), 32'h0123);

        // Reset while clr_cnt is 4 (dest 3 on the port).
        clr_start = 1'b1;
        push_clear(4);
        @(negedge clk);
        clr_start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_clr_dest3", 32'(reg_write_dest), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("held_rst");
        rst_n = 1'b1;
        push_clear(8);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("busy_restart", 32'(clr_busy), 32'(k < 7));
        end
        @(negedge clk);
        check("idle_end", 32'(reg_write_en), 32'd0);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_write_arbiter.md
Name: gpr_write_arbiter

Overview:
- Shares the single write port of the 8x16 general-purpose register file among NUM_REQ writeback sources, such as the ALU, load unit, immediate path and debug port.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Sequences a zero-clear of all registers after reset or on command, because the register file itself has no reset.
- Its registered outputs connect directly to the register file's reg_write_en, reg_write_dest and reg_write_data inputs.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- ADDR_W, 3, register address width.
- DATA_W, 16, register data width.
- NUM_REGS, 8, registers cleared by the clear sequence (equals 2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr_start  input  1  single-cycle pulse requesting a full register clear.
- clr_busy  output  1  high while the clear sequence runs.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  per-requester grant; transfer occurs when valid and ready are both high.
- req_dest  input  NUM_REQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- reg_write_en  output  1  register file write enable (registered).
- reg_write_dest  output  ADDR_W  register file write address (registered).
- reg_write_data  output  DATA_W  register file write data (registered).
- grant_id  output  $clog2(NUM_REQ)  index of the requester whose write is on the port this cycle (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clr_cnt=0, rr_ptr=0.
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0, grant_id=0.
  - clr_busy=1, req_ready=0.
  - The clear sequence starts automatically on the first clock after rst_n deasserts.
- States: CLEAR and ARB.
- CLEAR state:
  - Each cycle registers reg_write_en=1, reg_write_dest=clr_cnt, reg_write_data=0, then clr_cnt increments.
  - After clr_cnt=NUM_REGS-1 is issued, the next state is ARB and clr_cnt returns to 0.
  - The sequence is exactly NUM_REGS consecutive write cycles, addresses 0..7 in ascending order.
  - req_ready=0 throughout; clr_busy=1 throughout.
  - clr_start is ignored while in CLEAR.
- ARB state:
  - clr_busy=0.
  - The grant is combinational: the first requester with req_valid high, searching from index rr_ptr upward and wrapping modulo NUM_REQ.
  - At most one bit of req_ready is high, and only for the granted requester whose valid is high.
  - If no requester is valid, req_ready=0.
- Transfer and latency:
  - A transfer from requester g in cycle N gives, in cycle N+1: reg_write_en=1, reg_write_dest=req_dest[g], reg_write_data=req_data[g], grant_id=g.
  - The register file commits the write at the rising edge that ends cycle N+1.
  - Throughput is one write per cycle.
- Pointer update:
  - On a transfer, rr_ptr <= (g+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
- Idle port:
  - If there is no transfer in cycle N, reg_write_en=0 in cycle N+1.
  - reg_write_dest, reg_write_data and grant_id hold their previous values.
- clr_start in ARB:
  - Has priority over requests: all req_ready=0 that cycle and no transfer occurs.
  - Next state is CLEAR with clr_cnt=0.
  - A transfer accepted in the preceding cycle still completes, as the N+1 write, before the first clear write.
- Handshake rules:
  - req_ready depends on req_valid and rr_ptr only, never the reverse.
  - Requesters must hold valid, dest and data stable until ready.
- Same destination from several requesters:
  - No merging; each write is serialised in grant order.
  - The last-granted value wins in the register file.
- Reset mid-CLEAR or mid-transfer:
  - Any pending write is dropped.
  - The clear restarts at address 0 after reset is released.

Decomposition:
- Shared package gpr_pkg holds:
  - GPR_ADDR_W=3, GPR_DATA_W=16, GPR_NUM_REGS=8.
  - State encoding constants ST_CLEAR=1'b0 and ST_ARB=1'b1.
- One natural sub-module, rr_arbiter:
  - Purely combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and grant index.
  - Parameterised by NUM_REQ.
- The FSM, clear counter, pointer and output registers stay in gpr_write_arbiter.

Test Plan:
- Clear after reset: release rst_n, hold all req_valid=0.
  - Required: reg_write_en=1 for exactly 8 cycles with dest 0,1,...,7 and data 0x0000, clr_busy high for those 8 cycles.
  - Then reg_write_en=0, clr_busy=0, and every register read returns 0x0000.
- Single write: in ARB, req_valid=4'b0100, dest=5, data=0xBEEF.
  - Required: req_ready=4'b0100 in the same cycle.
  - Next cycle: reg_write_en=1, dest=5, data=0xBEEF, grant_id=2.
  - Register 5 reads 0xBEEF afterwards.
- Round-robin fairness: all four requesters continuously valid, rr_ptr=0.
  - Required: grants 0,1,2,3,0,1,... in consecutive cycles.
  - reg_write_en high every cycle with zero idle bubbles.
- Priority rotation: requesters 1 and 3 valid, rr_ptr=2.
  - Required: 3 is granted first, then 1 (pointer wraps to 0 and the search finds 1).
- clr_start collision: pulse clr_start in the same cycle req_valid[0]=1.
  - Required: req_ready=0 that cycle; the clear sequence 0..7 follows.
  - Requester 0, still valid, is granted in the first ARB cycle after the clear.
- Reset mid-clear: assert rst_n low while clr_cnt=4.
  - Required: outputs return to reset values immediately, without waiting for a clock edge.
  - After release, the clear restarts at dest 0 and runs a full 8 cycles.
